contador_bcd_n: RTL and testbench

CONTADOR_BCD_N -- requirements
Module: contador_bcd_n

---
 rtl/contador_bcd_n.sv | 102 ++++++++++
 tb/tb_contador_bcd_n.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/contador_bcd_n.sv
// N-digit BCD up/down counter with validated parallel load, terminal-count and overflow pulse.
// Optional macro CONTADOR_BCD_SAT_EN: saturate at the terminal value instead of wrapping.
module bcd_lane (
  input  logic [3:0] val,
  input  logic       up,
  input  logic       cin,
  output logic [3:0] nxt,
  output logic       cout,
  output logic       is9,
  output logic       is0
);
  always_comb begin
    nxt  = val;
    cout = 1'b0;
    if (cin) begin
      if (up) begin
        if (val == 4'd9) begin
          nxt  = 4'd0;
          cout = 1'b1;
        end else begin
          nxt = val + 4'd1;
        end
      end else begin
        if (val == 4'd0) begin
          nxt  = 4'd9;
          cout = 1'b1;
        end else begin
          nxt = val - 4'd1;
        end
      end
    end
  end

  assign is9 = (val == 4'd9);
  assign is0 = (val == 4'd0);
endmodule

module contador_bcd_n #(
  parameter int  DIGITS = 4,
  localparam int W      = 4*DIGITS
) (
  input  logic         clk_reloj,
  input  logic         rst_reset,
  input  logic         en_i,
  input  logic         up_i,
  input  logic         ld_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q,
  output logic         tc_o,
  output logic         carry_o,
  output logic         ld_err_o
);
  logic [DIGITS-1:0][3:0] cnt, nxt;
  logic [DIGITS-1:0]      cin, cy, is9, is0, bad;
  logic                   ovf;

  // Carry/borrow ripples combinationally through all lanes in one cycle.
  for (genvar k = 0; k < DIGITS; k++) begin : g_lane
    if (k == 0) begin : g_lsd
      assign cin[k] = 1'b1;
    end else begin : g_rest
      assign cin[k] = cy[k-1];
    end
    assign bad[k] = d_i[4*k+3] & (d_i[4*k+2] | d_i[4*k+1]);
    bcd_lane u_lane (
      .val  (cnt[k]),
      .up   (up_i),
      .cin  (cin[k]),
      .nxt  (nxt[k]),
      .cout (cy[k]),
      .is9  (is9[k]),
      .is0  (is0[k])
    );
  end

  // A carry out of the top lane is exactly "counting while at terminal value".
  assign ovf  = cy[DIGITS-1];
  assign tc_o = up_i ? (&is9) : (&is0);
  assign q    = cnt;

  always_ff @(posedge clk_reloj) begin
    if (rst_reset) begin
      cnt      <= '0;
      carry_o  <= 1'b0;
      ld_err_o <= 1'b0;
    end else begin
      carry_o  <= 1'b0;
      ld_err_o <= 1'b0;
      if (ld_i) begin
        if (|bad) ld_err_o <= 1'b1;
        else      cnt      <= d_i;
      end else if (en_i) begin
        carry_o <= ovf;
`ifdef CONTADOR_BCD_SAT_EN
        if (!ovf) cnt <= nxt;
`else
        cnt <= nxt;
`endif
      end
    end
  end
endmodule

// File: tb/tb_contador_bcd_n.sv
// Randomized + directed bench for contador_bcd_n (DIGITS=2) against a decimal integer model.
module tb_contador_bcd_n;
  localparam int DIGITS = 2;
  localparam int W      = 4*DIGITS;
  localparam int MAXV   = 99;

  logic         clk_reloj = 1'b0;
  logic         rst_reset, en_i, up_i, ld_i;
  logic [W-1:0] d_i, q;
  logic         tc_o, carry_o, ld_err_o;

  int checks = 0;
  int errors = 0;
  int m_val;
  bit m_carry, m_err, armed;
  int carry_cnt;

  contador_bcd_n #(.DIGITS(DIGITS)) dut (
    .clk_reloj (clk_reloj),
    .rst_reset (rst_reset),
    .en_i      (en_i),
    .up_i      (up_i),
    .ld_i      (ld_i),
    .d_i       (d_i),
    .q         (q),
    .tc_o      (tc_o),
    .carry_o   (carry_o),
    .ld_err_o  (ld_err_o)
  );

  always #5 clk_reloj = ~clk_reloj;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic bit is_bcd(input logic [W-1:0] v);
    for (int k = 0; k < DIGITS; k++)
      if (v[4*k +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int to_int(input logic [W-1:0] v);
    int r = 0;
    for (int k = DIGITS-1; k >= 0; k--) r = r*10 + int'(v[4*k +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int n);
    logic [W-1:0] r = '0;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction

  // One clock: drive inputs, check tc before the edge, advance model, check registered outputs.
  task automatic step(input bit rst, input bit ld, input bit en, input bit up,
                      input logic [W-1:0] d, input bit full);
    rst_reset = rst; ld_i = ld; en_i = en; up_i = up; d_i = d;
    #1;
    if (armed && full) chk("tc", {31'd0, tc_o}, {31'd0, (up ? (m_val == MAXV) : (m_val == 0))});
    @(posedge clk_reloj);
    if (rst) begin
      m_val = 0; m_carry = 0; m_err = 0; armed = 1;
    end else begin
      m_carry = 0; m_err = 0;
      if (ld) begin
        if (is_bcd(d)) m_val = to_int(d);
        else           m_err = 1;
      end else if (en) begin
        if (up) begin
          if (m_val == MAXV) begin
            m_carry = 1;
`ifndef CONTADOR_BCD_SAT_EN
            m_val = 0;
`endif
          end else m_val = m_val + 1;
        end else begin
          if (m_val == 0) begin
            m_carry = 1;
`ifndef CONTADOR_BCD_SAT_EN
            m_val = MAXV;
`endif
          end else m_val = m_val - 1;
        end
      end
    end
    #1;
    if (carry_o === 1'b1) carry_cnt++;
    if (full) begin
      chk("q", q, to_bcd(m_val));
      chk("carry", {31'd0, carry_o}, {31'd0, m_carry});
      chk("ld_err", {31'd0, ld_err_o}, {31'd0, m_err});
      chk("q_bcd", {31'd0, is_bcd(q)}, 32'd1);
    end
  endtask

  initial begin
    armed = 0; m_val = 0; m_carry = 0; m_err = 0; carry_cnt = 0;
    rst_reset = 1; ld_i = 0; en_i = 0; up_i = 1; d_i = '0;
    step(1, 0, 0, 1, '0, 1);
    chk("reset_q", q, '0);

    // full up sweep 00..99 and wrap
    carry_cnt = 0;
    for (int i = 0; i < 100; i++) step(0, 0, 1, 1, '0, 1);
    chk("sweep_end", q, '0);
    chk("sweep_carries", carry_cnt, 1);

    // load 00 then count down once
    step(0, 1, 0, 0, 8'h00, 1);
    step(0, 0, 1, 0, '0, 1);
`ifdef CONTADOR_BCD_SAT_EN
    chk("down_ovf_q", q, 8'h00);
`else
    chk("down_ovf_q", q, 8'h99);
`endif
    chk("down_ovf_carry", {31'd0, carry_o}, 32'd1);

    // rejected then accepted load
    step(0, 1, 1, 1, 8'h3A, 1);
    chk("bad_ld_err", {31'd0, ld_err_o}, 32'd1);
    step(0, 1, 1, 1, 8'h39, 1);
    chk("good_ld_q", q, 8'h39);

    // 19 -> 20 -> 19, then hold
    step(0, 1, 0, 1, 8'h19, 1);
    step(0, 0, 1, 1, '0, 1);
    chk("inc_19", q, 8'h20);
    step(0, 0, 1, 0, '0, 1);
    chk("dec_20", q, 8'h19);
    for (int i = 0; i < 5; i++) step(0, 0, 0, $urandom_range(0, 1), '0, 1);
    chk("hold_19", q, 8'h19);

    // reset beats load and count
    step(1, 1, 1, 1, 8'h55, 1);
    chk("rst_prio_q", q, '0);
    step(0, 0, 1, 1, '0, 1);
    chk("resume_q", q, 8'h01);

    // random stream; bias toward counting so terminals are reached
    for (int i = 0; i < 12000; i++) begin
      automatic int r = $urandom_range(0, 99);
      automatic bit rs = (r == 0);
      automatic bit ld = (r >= 1 && r <= 8);
      automatic logic [W-1:0] d = W'($urandom);
      if ($urandom_range(0, 3) == 0) d = (d[0]) ? 8'h99 : 8'h00;
      step(rs, ld, ($urandom_range(0, 4) != 0), ($urandom_range(0, 2) != 0), d, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
